ram_responder: RTL and testbench

//  Memory-side responder for the CPU data/instruction memory interface: accepts
//  one load or store request at a time, performs byte/half/word access on

---
 rtl/cpu_pkg.sv | 14 +
 rtl/ram_responder_bank.sv | 22 ++
 rtl/ram_responder.sv | 99 +++++++++
 tb/tb_ram_responder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU memory-interface types and the captured request struct
package cpu_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [2:0] {LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101} lfunc_t;
    typedef enum logic [2:0] {SB = 3'b000, SH = 3'b001, SW = 3'b010} sfunc_t;
    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [2:0] func3;
        word_t      addr;
        word_t      wdata;
    } ramreq_t;
endpackage

// File: rtl/ram_responder_bank.sv
// ram_bank: DEPTH x 32 word storage with byte enables, synchronous write, combinational read
module ram_bank #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];

    // byte-lane write; storage is deliberately never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (i_we && i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/ram_responder.sv
// ram_responder: latency-programmable load/store memory responder; RAM_MISALIGN_ERR_EN turns misaligned half/word access into ERROR
module ram_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic      clk,
    input  logic      nRst,
    input  logic      req_rd,
    input  logic      req_wr,
    input  word_t     addr,
    input  logic [2:0] func3,
    input  word_t     wdata,
    output ramstate_t state,
    output logic      ack,
    output word_t     rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    ramstate_t     r_state, w_next;
    logic [CW-1:0] r_cnt;
    ramreq_t       r_req, w_in, w_cur;
    word_t         r_rdata, w_mem, w_lane, w_load, w_wdata;
    logic [3:0]    w_be;
    logic          w_req, w_err, w_mis, w_go;

    assign w_in  = '{rd: req_rd, wr: req_wr, func3: func3, addr: addr, wdata: wdata};
    assign w_req = req_rd | req_wr;
    // with LATENCY==1 the access happens straight out of FREE, so use live inputs there
    assign w_cur = (r_state == FREE) ? w_in : r_req;
`ifdef RAM_MISALIGN_ERR_EN
    assign w_mis = (func3[1:0] == 2'b01 && addr[0]) || (func3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif
    assign w_err = (req_rd & req_wr)
                 | ({2'b00, addr[31:2]} >= 32'(DEPTH))
                 | (req_rd ? !(func3 inside {LB, LH, LW, LBU, LHU}) : (func3 > 3'd2))
                 | w_mis;

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            FREE:    if (w_req) w_next = w_err ? ERROR : (LATENCY == 1 ? ACCESS : BUSY);
            BUSY:    if (r_cnt == CW'(1)) w_next = ACCESS;
            default: w_next = FREE;
        endcase
    end

    assign w_go = (w_next == ACCESS);

    // little-endian lane steering for stores and extraction/extension for loads
    always_comb begin
        w_be    = w_cur.func3[1:0] == 2'b00 ? 4'b0001 << w_cur.addr[1:0] :
                  w_cur.func3[1:0] == 2'b01 ? (w_cur.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_wdata = w_cur.func3[1:0] == 2'b00 ? {4{w_cur.wdata[7:0]}} :
                  w_cur.func3[1:0] == 2'b01 ? {2{w_cur.wdata[15:0]}} : w_cur.wdata;
        w_lane  = w_mem >> (w_cur.func3[1:0] == 2'b01 ? {w_cur.addr[1], 4'b0000} : {w_cur.addr[1:0], 3'b000});
        w_load  = w_cur.func3[1] ? w_mem :
                  w_cur.func3[0] ? {{16{~w_cur.func3[2] & w_lane[15]}}, w_lane[15:0]} :
                                   {{24{~w_cur.func3[2] & w_lane[7]}}, w_lane[7:0]};
    end

    ram_bank #(.DEPTH(DEPTH)) u_bank (
        .clk     (clk),
        .i_we    (w_go & w_cur.wr),
        .i_be    (w_be),
        .i_addr  (w_cur.addr[AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_mem)
    );

    // state, latency counter, captured request and registered load data
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= FREE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == FREE && w_req) begin
                r_req <= w_in;
                r_cnt <= CW'(LATENCY - 1);
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_go && w_cur.rd) r_rdata <= w_load;
            else if (w_next == ERROR) r_rdata <= '0;
        end
    end

    assign state = r_state;
    assign ack   = (r_state == ACCESS) || (r_state == ERROR);
    assign rdata = r_rdata;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed plus random load/store traffic against a byte-level reference model
module tb_ram_responder;
    import cpu_pkg::*;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int NW    = 32;

    logic        clk = 1'b0, nRst = 1'b0, req_rd = 1'b0, req_wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [2:0]  func3 = '0;
    ramstate_t   state;
    logic        ack;
    logic [31:0] rdata;

    logic [31:0] mem_m [NW];
    logic [31:0] exp_rdata;
    int          n_pass = 0, n_tot = 0;

    ram_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .nRst(nRst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
        .func3(func3), .wdata(wdata), .state(state), .ack(ack), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // reference: decides error, applies the store, predicts rdata from byte arithmetic
    task automatic model(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output logic err);
        int unsigned off, w, x, lane_hit;
        off = a % 4;
        err = (rd && wr) || (a / 4 >= DEPTH) || (rd ? !(f3 inside {0, 1, 2, 4, 5}) : (f3 > 2));
`ifdef RAM_MISALIGN_ERR_EN
        if ((f3 % 4 == 1 && a % 2 != 0) || (f3 % 4 == 2 && off != 0)) err = 1'b1;
`endif
        if (err) begin
            exp_rdata = 0;
            return;
        end
        if (rd) begin
            w = mem_m[a / 4];
            if (f3 % 4 == 2) exp_rdata = w;
            else if (f3 % 4 == 1) begin
                x = (w >> (16 * (off / 2))) % 65536;
                if (f3 == 1 && x >= 32768) x = x - 65536;
                exp_rdata = x;
            end else begin
                x = (w >> (8 * off)) % 256;
                if (f3 == 0 && x >= 128) x = x - 256;
                exp_rdata = x;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                lane_hit = (f3 == 2) || (f3 == 1 && i / 2 == off / 2) || (f3 == 0 && i == off);
                if (lane_hit != 0)
                    mem_m[a / 4][8*i +: 8] = (f3 == 2) ? wd[8*i +: 8] : (f3 == 1) ? wd[8*(i%2) +: 8] : wd[7:0];
            end
        end
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        logic err;
        int   n;
        chk("idle_state", state, FREE);
        model(rd, wr, a, f3, wd, err);
        req_rd = rd; req_wr = wr; addr = a; func3 = f3; wdata = wd;
        n = 0;
        do begin
            @(posedge clk); @(negedge clk); n++;
            if (n == 1 && !err) chk("busy_state", state, BUSY);
        end while (!ack && n < 20);
        chk("ack", ack, 1'b1);
        chk("latency", n, err ? 1 : LAT);
        chk("ack_state", state, err ? ERROR : ACCESS);
        chk("rdata", rdata, exp_rdata);
        req_rd = 0; req_wr = 0;
        @(posedge clk); @(negedge clk);
        chk("ack_drop", ack, 1'b0);
    endtask

    initial begin
        exp_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_state", state, FREE);
        chk("rst_ack", ack, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        nRst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NW; i++) txn(0, 1, 32'(i * 4), 3'd2, $urandom);
        txn(0, 1, 32'h10, 3'd2, 32'hDEADBEEF);
        txn(1, 0, 32'h10, 3'd2, 0);  chk("lw_10", rdata, 32'hDEADBEEF);
        txn(1, 0, 32'h13, 3'd0, 0);  chk("lb_13", rdata, 32'hFFFFFFDE);
        txn(1, 0, 32'h13, 3'd4, 0);  chk("lbu_13", rdata, 32'h000000DE);
        txn(1, 0, 32'h12, 3'd5, 0);  chk("lhu_12", rdata, 32'h0000DEAD);
        txn(0, 1, 32'h11, 3'd0, 32'h55);
        txn(1, 0, 32'h10, 3'd2, 0);  chk("sb_11", rdata, 32'hDEAD55EF);
        txn(0, 1, 32'h12, 3'd1, 32'h1234);
        txn(1, 0, 32'h10, 3'd2, 0);  chk("sh_12", rdata, 32'h123455EF);
        txn(1, 1, 32'h10, 3'd2, 32'h0);                chk("both_rdata", rdata, 32'h0);
        txn(1, 0, 32'(DEPTH * 4), 3'd2, 0);
        txn(0, 1, 32'(DEPTH * 4), 3'd2, 32'hFFFFFFFF);
        txn(1, 0, 32'h10, 3'd2, 0);  chk("intact", rdata, 32'h123455EF);
        txn(1, 0, 32'h11, 3'd2, 0);
        // reset during BUSY must drop the store
        txn(0, 1, 32'h20, 3'd2, 32'h11223344);
        req_wr = 1; addr = 32'h20; func3 = 3'd2; wdata = 32'hAAAAAAAA;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_busy", state, BUSY);
        nRst = 1'b0;
        #1;
        chk("mid_rst_state", state, FREE);
        chk("mid_rst_ack", ack, 1'b0);
        chk("mid_rst_rdata", rdata, 32'h0);
        req_wr = 0;
        exp_rdata = 0;
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        txn(1, 0, 32'h20, 3'd2, 0);  chk("abort_kept", rdata, 32'h11223344);
        for (int k = 0; k < 250; k++) begin
            logic [1:0]  kind;
            logic [31:0] a;
            kind = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(1, 2));
            a = ($urandom_range(0, 19) == 0) ? 32'(DEPTH * 4) + $urandom_range(0, 4095) : $urandom_range(0, NW * 4 - 1);
            txn(kind[0], kind[1], a, 3'($urandom_range(0, 7)), $urandom);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
